// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 valid/ready stream mux, fixed-select or round-robin, registered output
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt;
  logic             rr_found;
  logic [SELW-1:0]  rr_gnt;
  logic             fix_vld;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin search starts just after the last granted channel and wraps.
  always_comb begin
    rr_found = 1'b0;
    rr_gnt   = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!rr_found && in_valid[(int'(ptr_q) + k) % NCH]) begin
        rr_found = 1'b1;
        rr_gnt   = SELW'((int'(ptr_q) + k) % NCH);
      end
    end
  end

  // Compare against each legal index so an out-of-range sel simply matches nothing.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) fix_vld = in_valid[i];
    end
  end

  always_comb begin
    gnt_vld = mode ? rr_found : fix_vld;
    gnt     = mode ? rr_gnt : sel;
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt == SELW'(i)) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load_en && gnt_vld;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = gnt_data;
        out_ch_d   = gnt;
        if (mode) ptr_d = gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed bench for stream_mux_rr (NCH=4 and NCH=3 builds)
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;

  logic        a_mode;
  logic [1:0]  a_sel;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic [7:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [1:0]  a_out_ch;

  logic        b_mode;
  logic [1:0]  b_sel;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_out_ch;

  int errors;
  int checks;

  stream_mux_rr #(.WIDTH(8), .NCH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ch(a_out_ch)
  );

  stream_mux_rr #(.WIDTH(8), .NCH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ch(b_out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] t4_seq [4];

  initial begin
    errors = 0;
    checks = 0;
    t4_seq = '{2'd3, 2'd1, 2'd3, 2'd1};

    rst_n       = 1'b0;
    a_mode      = 1'b0;
    a_sel       = 2'd0;
    a_in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_in_valid  = 4'h0;
    a_out_ready = 1'b0;
    b_mode      = 1'b0;
    b_sel       = 2'd0;
    b_in_data   = {8'hC2, 8'hC1, 8'hC0};
    b_in_valid  = 3'h0;
    b_out_ready = 1'b0;

    #2;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'h00);
    check("rst_out_ch", 32'(a_out_ch), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Fixed select, channel 2
    a_mode      = 1'b0;
    a_sel       = 2'd2;
    a_in_valid  = 4'hF;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fix_in_ready", 32'(a_in_ready), 32'b0100);
      tick();
      check("fix_out_data", 32'(a_out_data), 32'hA2);
      check("fix_out_ch", 32'(a_out_ch), 32'd2);
      check("fix_out_valid", 32'(a_out_valid), 32'd1);
    end

    // Round robin, all valid: pointer still at 3 from reset, so starts at 0
    a_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_in_ready", 32'(a_in_ready), 32'(4'b0001 << (i % 4)));
      tick();
      check("rr_out_ch", 32'(a_out_ch), 32'(i % 4));
      check("rr_out_data", 32'(a_out_data), 32'(8'hA0 + (i % 4)));
    end

    // Round robin sparse 1010, pointer at 1
    a_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sparse_in_ready", 32'(a_in_ready), 32'(4'b0001 << t4_seq[i]));
      tick();
      check("sparse_out_ch", 32'(a_out_ch), 32'(t4_seq[i]));
      check("sparse_out_data", 32'(a_out_data), 32'(8'hA0 + t4_seq[i]));
    end

    // Backpressure holding channel 1's word
    a_in_valid  = 4'hF;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(a_in_ready), 32'd0);
      tick();
      check("bp_out_data", 32'(a_out_data), 32'hA1);
      check("bp_out_ch", 32'(a_out_ch), 32'd1);
      check("bp_out_valid", 32'(a_out_valid), 32'd1);
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_rel_in_ready", 32'(a_in_ready), 32'b0100);
    tick();
    check("bp_rel_out_ch", 32'(a_out_ch), 32'd2);
    check("bp_rel_out_data", 32'(a_out_data), 32'hA2);
    #1;
    check("bp_next_in_ready", 32'(a_in_ready), 32'b1000);
    tick();
    check("bp_next_out_ch", 32'(a_out_ch), 32'd3);

    // Asynchronous reset mid-stream with a word held
    a_in_valid = 4'b1010;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(a_out_valid), 32'd0);
    check("midrst_out_data", 32'(a_out_data), 32'h00);
    check("midrst_out_ch", 32'(a_out_ch), 32'd0);
    check("midrst_in_ready", 32'(a_in_ready), 32'b0010);
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_out_ch", 32'(a_out_ch), 32'd1);
    check("postrst_out_data", 32'(a_out_data), 32'hA1);
    check("postrst_out_valid", 32'(a_out_valid), 32'd1);
    a_in_valid = 4'h0;

    // NCH=3 build: legal sel, then sel with invalid channel, then out-of-range sel
    b_mode      = 1'b0;
    b_sel       = 2'd2;
    b_in_valid  = 3'b111;
    b_out_ready = 1'b1;
    #1;
    check("n3_in_ready", 32'(b_in_ready), 32'b100);
    tick();
    check("n3_out_valid", 32'(b_out_valid), 32'd1);
    check("n3_out_data", 32'(b_out_data), 32'hC2);
    check("n3_out_ch", 32'(b_out_ch), 32'd2);
    b_sel      = 2'd0;
    b_in_valid = 3'b110;
    #1;
    check("n3_sel_invalid_in_ready", 32'(b_in_ready), 32'b000);
    b_sel      = 2'd3;
    b_in_valid = 3'b111;
    #1;
    check("n3_oob_in_ready", 32'(b_in_ready), 32'b000);
    tick();
    check("n3_oob_out_valid", 32'(b_out_valid), 32'd0);
    check("n3_oob_out_data", 32'(b_out_data), 32'hC2);
    check("n3_oob_out_ch", 32'(b_out_ch), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
